// File: rtl/garegga_snd_pkg.sv
// ============================================================================
// garegga_snd_pkg : shared types and defaults for the sound ROM arbiter
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

package garegga_snd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH_Z = 2'd1,
    FETCH_P = 2'd2
  } state_e;

  localparam logic [21:0] Z_BASE_DEF = 22'h000000;
  localparam logic [21:0] P_BASE_DEF = 22'h040000;

  typedef logic [7:0] byte_t;

endpackage

`default_nettype wire

// File: rtl/garegga_rom_slot.sv
// ============================================================================
// garegga_rom_slot : one-entry tag/data cache with hit compare and flush
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module garegga_rom_slot
  import garegga_snd_pkg::*;
#(
  parameter int AW = 17
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          fill_i,
  input  logic [AW-1:0] fill_tag_i,
  input  byte_t         fill_data_i,
  input  logic          cs_i,
  input  logic [AW-1:0] addr_i,
  output logic          hit_o,
  output byte_t         dout_o
);

  logic [AW-1:0] tag_q;
  byte_t         data_q;
  logic          valid_q;

  // Flush wins over a coincident fill so a stale line can never become valid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (fill_i) begin
      tag_q   <= fill_tag_i;
      data_q  <= fill_data_i;
      valid_q <= 1'b1;
    end
  end

  assign hit_o  = cs_i & valid_q & (addr_i == tag_q);
  assign dout_o = data_q;

endmodule

`default_nettype wire

// File: rtl/garegga_snd_rom_arb.sv
// ============================================================================
// garegga_snd_rom_arb : Z80 ROM / OKI PCM sharing of one SDRAM read channel
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module garegga_snd_rom_arb
  import garegga_snd_pkg::*;
#(
  parameter int              ZW     = 17,
  parameter int              PW     = 20,
  parameter int              SW     = 22,
  parameter logic [SW-1:0]   Z_BASE = SW'(Z_BASE_DEF),
  parameter logic [SW-1:0]   P_BASE = SW'(P_BASE_DEF),
  parameter int              STARVE = 4
) (
  input  logic          CLK96,
  input  logic          RESET96,
  input  logic          FLUSH,
  input  logic          Z_CS,
  input  logic [ZW-1:0] Z_ADDR,
  output logic [7:0]    Z_DOUT,
  output logic          Z_OK,
  input  logic          P_CS,
  input  logic [PW-1:0] P_ADDR,
  output logic [7:0]    P_DOUT,
  output logic          P_OK,
  output logic          SDR_CS,
  output logic [SW-1:0] SDR_ADDR,
  input  logic [7:0]    SDR_DATA,
  input  logic          SDR_OK
);

  localparam int             SKW      = $clog2(STARVE + 1);
  localparam logic [SKW-1:0] STARVE_C = SKW'(STARVE);

  state_e          state_q, state_d;
  logic [SW-1:0]   sdr_addr_q, sdr_addr_d;
  logic [ZW-1:0]   ztag_q, ztag_d;
  logic [PW-1:0]   ptag_q, ptag_d;
  logic [SKW-1:0]  streak_q, streak_d;
  logic            discard_q, discard_d;

  logic z_hit, p_hit, z_miss, p_miss;
  logic grant_z, grant_p;
  logic z_fill, p_fill, sdr_cs;

  assign z_miss = Z_CS & ~z_hit;
  assign p_miss = P_CS & ~p_hit;

  // Z80 wins unless the PCM side has already waited out STARVE Z80 grants.
  assign grant_z = (state_q == IDLE) & z_miss & (~p_miss | (streak_q < STARVE_C));
  assign grant_p = (state_q == IDLE) & p_miss & ~grant_z;

  always_ff @(posedge CLK96) begin
    if (RESET96) begin
      state_q    <= IDLE;
      sdr_addr_q <= '0;
      ztag_q     <= '0;
      ptag_q     <= '0;
      streak_q   <= '0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sdr_addr_q <= sdr_addr_d;
      ztag_q     <= ztag_d;
      ptag_q     <= ptag_d;
      streak_q   <= streak_d;
      discard_q  <= discard_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sdr_addr_d = sdr_addr_q;
    ztag_d     = ztag_q;
    ptag_d     = ptag_q;
    streak_d   = streak_q;
    discard_d  = discard_q;
    case (state_q)
      IDLE: begin
        discard_d = 1'b0;
        if (grant_z) begin
          state_d    = FETCH_Z;
          ztag_d     = Z_ADDR;
          sdr_addr_d = Z_BASE + SW'(Z_ADDR);
          if (!p_miss)
            streak_d = '0;
          else if (streak_q != STARVE_C)
            streak_d = streak_q + SKW'(1);
        end else if (grant_p) begin
          state_d    = FETCH_P;
          ptag_d     = P_ADDR;
          sdr_addr_d = P_BASE + SW'(P_ADDR);
          streak_d   = '0;
        end
      end
      FETCH_Z, FETCH_P: begin
        // A flush anywhere during the fetch poisons its eventual fill.
        if (FLUSH)
          discard_d = 1'b1;
        if (SDR_OK)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sdr_cs = 1'b0;
    z_fill = 1'b0;
    p_fill = 1'b0;
    case (state_q)
      FETCH_Z: begin
        sdr_cs = 1'b1;
        z_fill = SDR_OK & ~FLUSH & ~discard_q;
      end
      FETCH_P: begin
        sdr_cs = 1'b1;
        p_fill = SDR_OK & ~FLUSH & ~discard_q;
      end
      default: ;
    endcase
  end

  assign SDR_CS   = sdr_cs;
  assign SDR_ADDR = sdr_addr_q;

  garegga_rom_slot #(.AW(ZW)) u_zslot (
    .clk_i       (CLK96),
    .rst_i       (RESET96),
    .flush_i     (FLUSH),
    .fill_i      (z_fill),
    .fill_tag_i  (ztag_q),
    .fill_data_i (SDR_DATA),
    .cs_i        (Z_CS),
    .addr_i      (Z_ADDR),
    .hit_o       (z_hit),
    .dout_o      (Z_DOUT)
  );

  garegga_rom_slot #(.AW(PW)) u_pslot (
    .clk_i       (CLK96),
    .rst_i       (RESET96),
    .flush_i     (FLUSH),
    .fill_i      (p_fill),
    .fill_tag_i  (ptag_q),
    .fill_data_i (SDR_DATA),
    .cs_i        (P_CS),
    .addr_i      (P_ADDR),
    .hit_o       (p_hit),
    .dout_o      (P_DOUT)
  );

  assign Z_OK = z_hit;
  assign P_OK = p_hit;

endmodule

`default_nettype wire

// File: tb/tb_garegga_snd_rom_arb.sv
// ============================================================================
// tb_garegga_snd_rom_arb : directed self-checking bench for the sound ROM arbiter
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_garegga_snd_rom_arb;

  logic        CLK96 = 1'b0;
  logic        RESET96 = 1'b1;
  logic        FLUSH = 1'b0;
  logic        Z_CS = 1'b0;
  logic [16:0] Z_ADDR = '0;
  logic [7:0]  Z_DOUT;
  logic        Z_OK;
  logic        P_CS = 1'b0;
  logic [19:0] P_ADDR = '0;
  logic [7:0]  P_DOUT;
  logic        P_OK;
  logic        SDR_CS;
  logic [21:0] SDR_ADDR;
  logic [7:0]  SDR_DATA = '0;
  logic        SDR_OK = 1'b0;

  int checks = 0;
  int failures = 0;

  // SDRAM model state
  localparam int LAT = 5;
  logic        ovr_en = 1'b0;
  logic [7:0]  ovr_data = '0;
  logic        busy = 1'b0;
  int          cnt = 0;
  logic [21:0] req = '0;

  garegga_snd_rom_arb dut (
    .CLK96    (CLK96),
    .RESET96  (RESET96),
    .FLUSH    (FLUSH),
    .Z_CS     (Z_CS),
    .Z_ADDR   (Z_ADDR),
    .Z_DOUT   (Z_DOUT),
    .Z_OK     (Z_OK),
    .P_CS     (P_CS),
    .P_ADDR   (P_ADDR),
    .P_DOUT   (P_DOUT),
    .P_OK     (P_OK),
    .SDR_CS   (SDR_CS),
    .SDR_ADDR (SDR_ADDR),
    .SDR_DATA (SDR_DATA),
    .SDR_OK   (SDR_OK)
  );

  always #5 CLK96 = ~CLK96;

  // Returns data LAT cycles after a request is seen; default data is addr[7:0]^5A.
  initial begin
    forever begin
      @(posedge CLK96);
      #1;
      if (SDR_OK) begin
        SDR_OK = 1'b0;
        busy   = 1'b0;
      end else if (busy) begin
        if (!SDR_CS) begin
          busy = 1'b0;
        end else begin
          cnt++;
          if (cnt >= LAT) begin
            SDR_OK   = 1'b1;
            SDR_DATA = ovr_en ? ovr_data : (req[7:0] ^ 8'h5A);
          end
        end
      end else if (SDR_CS) begin
        busy = 1'b1;
        cnt  = 1;
        req  = SDR_ADDR;
      end
    end
  end

  task automatic wait_grant(output bit ok);
    int n;
    n = 0;
    while (SDR_CS && n < 100) begin @(negedge CLK96); n++; end
    while (!SDR_CS && n < 100) begin @(negedge CLK96); n++; end
    ok = SDR_CS;
  endtask

  task automatic wait_zok(output bit ok);
    int n;
    n = 0;
    while (!Z_OK && n < 100) begin @(negedge CLK96); n++; end
    ok = Z_OK;
  endtask

  task automatic wait_pok(output bit ok);
    int n;
    n = 0;
    while (!P_OK && n < 100) begin @(negedge CLK96); n++; end
    ok = P_OK;
  endtask

  task automatic test_reset();
    bit bad;
    RESET96 = 1'b1;
    repeat (3) @(negedge CLK96);
    checks++; if (SDR_CS !== 1'b0) begin failures++; $display("FAIL reset_sdr_cs: got %b expected 0", SDR_CS); end
    checks++; if (SDR_ADDR !== 22'h0) begin failures++; $display("FAIL reset_sdr_addr: got %h expected 000000", SDR_ADDR); end
    checks++; if (Z_DOUT !== 8'h00) begin failures++; $display("FAIL reset_z_dout: got %h expected 00", Z_DOUT); end
    checks++; if (P_DOUT !== 8'h00) begin failures++; $display("FAIL reset_p_dout: got %h expected 00", P_DOUT); end
    checks++; if (Z_OK !== 1'b0) begin failures++; $display("FAIL reset_z_ok: got %b expected 0", Z_OK); end
    checks++; if (P_OK !== 1'b0) begin failures++; $display("FAIL reset_p_ok: got %b expected 0", P_OK); end
    RESET96 = 1'b0;
    bad = 1'b0;
    repeat (5) begin
      @(negedge CLK96);
      if (SDR_CS !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin failures++; $display("FAIL idle_sdr_cs: got 1 expected 0"); end
  endtask

  task automatic test_z_miss();
    bit ok, bad;
    ovr_en = 1'b1; ovr_data = 8'hA5;
    Z_CS = 1'b1; Z_ADDR = 17'h0_1234;
    #1;
    checks++; if (Z_OK !== 1'b0) begin failures++; $display("FAIL zmiss_ok_before: got %b expected 0", Z_OK); end
    wait_grant(ok);
    checks++; if (!ok) begin failures++; $display("FAIL zmiss_grant: got timeout expected SDR_CS"); end
    checks++; if (SDR_ADDR !== 22'h001234) begin failures++; $display("FAIL zmiss_addr: got %h expected 001234", SDR_ADDR); end
    wait_zok(ok);
    checks++; if (!ok) begin failures++; $display("FAIL zmiss_ok: got timeout expected Z_OK=1"); end
    checks++; if (Z_DOUT !== 8'hA5) begin failures++; $display("FAIL zmiss_dout: got %h expected a5", Z_DOUT); end
    bad = 1'b0;
    repeat (10) begin
      @(negedge CLK96);
      if (SDR_CS !== 1'b0 || Z_OK !== 1'b1 || Z_DOUT !== 8'hA5) bad = 1'b1;
    end
    checks++; if (bad) begin failures++; $display("FAIL zhit_hold: got refetch/lost hit expected steady hit a5"); end
    ovr_en = 1'b0;
  endtask

  task automatic test_pcm_offset();
    bit ok;
    Z_CS = 1'b0;
    ovr_en = 1'b1; ovr_data = 8'h3C;
    P_CS = 1'b1; P_ADDR = 20'h1_0000;
    wait_grant(ok);
    checks++; if (!ok) begin failures++; $display("FAIL pcm_grant: got timeout expected SDR_CS"); end
    checks++; if (SDR_ADDR !== 22'h050000) begin failures++; $display("FAIL pcm_addr: got %h expected 050000", SDR_ADDR); end
    wait_pok(ok);
    checks++; if (!ok) begin failures++; $display("FAIL pcm_ok: got timeout expected P_OK=1"); end
    checks++; if (P_DOUT !== 8'h3C) begin failures++; $display("FAIL pcm_dout: got %h expected 3c", P_DOUT); end
    P_CS = 1'b0;
    ovr_en = 1'b0;
    repeat (3) @(negedge CLK96);
  endtask

  task automatic test_contention();
    bit ok;
    logic [16:0] za;
    logic [19:0] pa;
    logic [21:0] exp_a;
    za = 17'h0_2000;
    pa = 20'h2_0000;
    Z_ADDR = za; P_ADDR = pa;
    Z_CS = 1'b1; P_CS = 1'b1;
    for (int g = 0; g < 15; g++) begin
      wait_grant(ok);
      checks++;
      if (!ok) begin
        failures++; $display("FAIL contention_grant%0d: got timeout expected SDR_CS", g);
        break;
      end
      exp_a = (g % 5 == 4) ? (22'h040000 + 22'(pa)) : 22'(za);
      if (SDR_ADDR !== exp_a) begin
        failures++; $display("FAIL contention_grant%0d: got addr %h expected %h", g, SDR_ADDR, exp_a);
      end
      // Move the granted requester on so both sides keep missing.
      if (SDR_ADDR >= 22'h040000) begin pa = pa + 20'd1; P_ADDR = pa; end
      else begin za = za + 17'd1; Z_ADDR = za; end
    end
    Z_CS = 1'b0; P_CS = 1'b0;
    repeat (20) @(negedge CLK96);
  endtask

  task automatic test_addr_change();
    bit ok, glitch, seen_low;
    int n;
    Z_CS = 1'b1; Z_ADDR = 17'h0_0100;
    wait_grant(ok);
    checks++; if (!ok || SDR_ADDR !== 22'h000100) begin failures++; $display("FAIL achg_first_addr: got %h expected 000100", SDR_ADDR); end
    @(negedge CLK96);
    Z_ADDR = 17'h0_0101;
    glitch = 1'b0; seen_low = 1'b0; n = 0;
    while (n < 60 && !(seen_low && SDR_CS)) begin
      @(negedge CLK96);
      n++;
      if (!SDR_CS) seen_low = 1'b1;
      if (Z_OK !== 1'b0 && !(seen_low && SDR_CS)) glitch = 1'b1;
    end
    checks++; if (glitch) begin failures++; $display("FAIL achg_ok_stale: got Z_OK=1 expected 0"); end
    checks++; if (!(seen_low && SDR_CS) || SDR_ADDR !== 22'h000101) begin failures++; $display("FAIL achg_refetch_addr: got %h expected 000101", SDR_ADDR); end
    wait_zok(ok);
    checks++; if (!ok || Z_DOUT !== 8'h5B) begin failures++; $display("FAIL achg_dout: got %h expected 5b", Z_DOUT); end
    Z_CS = 1'b0;
    repeat (3) @(negedge CLK96);
  endtask

  task automatic test_flush_reset();
    bit ok;
    int n;
    P_CS = 1'b1; P_ADDR = 20'h0_0123;
    wait_grant(ok);
    checks++; if (!ok || SDR_ADDR !== 22'h040123) begin failures++; $display("FAIL flush_addr: got %h expected 040123", SDR_ADDR); end
    @(negedge CLK96);
    FLUSH = 1'b1;
    @(negedge CLK96);
    FLUSH = 1'b0;
    n = 0;
    while (SDR_CS && n < 50) begin @(negedge CLK96); n++; end
    checks++; if (SDR_CS) begin failures++; $display("FAIL flush_complete: got timeout expected SDR_CS=0"); end
    checks++; if (P_OK !== 1'b0) begin failures++; $display("FAIL flush_no_fill: got P_OK=%b expected 0", P_OK); end
    wait_grant(ok);
    checks++; if (!ok) begin failures++; $display("FAIL flush_regrant: got timeout expected SDR_CS"); end
    @(negedge CLK96);
    RESET96 = 1'b1;
    @(negedge CLK96);
    RESET96 = 1'b0;
    checks++; if (SDR_CS !== 1'b0) begin failures++; $display("FAIL rst_mid_cs: got %b expected 0", SDR_CS); end
    checks++; if (SDR_ADDR !== 22'h0) begin failures++; $display("FAIL rst_mid_addr: got %h expected 000000", SDR_ADDR); end
    checks++; if (P_OK !== 1'b0 || P_DOUT !== 8'h00) begin failures++; $display("FAIL rst_mid_p: got ok=%b dout=%h expected ok=0 dout=00", P_OK, P_DOUT); end
    wait_grant(ok);
    checks++; if (!ok || SDR_ADDR !== 22'h040123) begin failures++; $display("FAIL rst_refetch_addr: got %h expected 040123", SDR_ADDR); end
    wait_pok(ok);
    checks++; if (!ok || P_DOUT !== 8'h79) begin failures++; $display("FAIL rst_refetch_dout: got %h expected 79", P_DOUT); end
    P_CS = 1'b0;
  endtask

  initial begin
    test_reset();
    test_z_miss();
    test_pcm_offset();
    test_contention();
    test_addr_change();
    test_flush_reset();
    repeat (2) @(negedge CLK96);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
